// File: rtl/sigma_delta_adc_if.sv
// Bundle of the sigma-delta ADC signals shared between the converter and its user.
// The converter sits on the slave modport; the sample consumer/stimulus side is the master.
interface sigma_delta_adc_if;
  logic        CMP_IN;
  logic        ENABLE;
  logic        FB_OUT;
  logic [15:0] SAMPLE;
  logic        SAMPLE_VALID;

  modport master (
    output CMP_IN,
    output ENABLE,
    input  FB_OUT,
    input  SAMPLE,
    input  SAMPLE_VALID
  );

  modport slave (
    input  CMP_IN,
    input  ENABLE,
    output FB_OUT,
    output SAMPLE,
    output SAMPLE_VALID
  );
endinterface

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC front end: synchronised comparator bit drives the loop feedback
// and a sinc2 CIC decimator producing excess-2**15 samples every 2**DEC_LOG2 clocks.
module sigma_delta_adc #(
  parameter int unsigned DEC_LOG2 = 8,
  parameter logic        INV      = 1'b1
) (
  input logic               CLK,
  input logic               RESET,
  sigma_delta_adc_if.slave  bus
);

  localparam int unsigned W     = 2 * DEC_LOG2 + 1;
  localparam int unsigned SHIFT = 16 - 2 * DEC_LOG2;

  logic                sync1_q, sync2_q, d_q, fb_q;
  logic [W-1:0]        i1_q, i1_d;
  logic [W-1:0]        i2_q, i2_d;
  logic [W-1:0]        i2_dly_q, i2_dly_d;
  logic [W-1:0]        c1_dly_q, c1_dly_d;
  logic [W-1:0]        raw_q, raw_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]          wu_q, wu_d;
  logic                pend_q, pend_d;
  logic [15:0]         sample_q, sample_d;
  logic                valid_q, valid_d;

  logic                tc;
  logic [W-1:0]        c1, c2;
  logic [16:0]         scaled;

  always_comb begin
    i1_d     = i1_q;
    i2_d     = i2_q;
    i2_dly_d = i2_dly_q;
    c1_dly_d = c1_dly_q;
    raw_d    = raw_q;
    cnt_d    = cnt_q;
    wu_d     = wu_q;
    pend_d   = 1'b0;
    sample_d = sample_q;
    valid_d  = 1'b0;

    tc     = bus.ENABLE && (&cnt_q);
    c1     = i2_q - i2_dly_q;
    c2     = c1 - c1_dly_q;
    scaled = 17'(raw_q) << SHIFT;

    if (!bus.ENABLE) begin
      i1_d     = '0;
      i2_d     = '0;
      i2_dly_d = '0;
      c1_dly_d = '0;
      cnt_d    = '0;
      wu_d     = 2'd0;
    end else begin
      i1_d  = i1_q + W'(d_q);
      i2_d  = i2_q + i1_q;
      cnt_d = cnt_q + 1'b1;
      if (tc) begin
        i2_dly_d = i2_q;
        c1_dly_d = c1;
        raw_d    = c2;
        // The first two combs still see the zeroed delay registers.
        pend_d   = (wu_q == 2'd2);
        wu_d     = (wu_q == 2'd2) ? 2'd2 : wu_q + 2'd1;
      end
    end

    if (pend_q && bus.ENABLE) begin
      valid_d  = 1'b1;
      sample_d = scaled[16] ? 16'hFFFF : scaled[15:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      d_q      <= 1'b0;
      fb_q     <= INV;
      i1_q     <= '0;
      i2_q     <= '0;
      i2_dly_q <= '0;
      c1_dly_q <= '0;
      raw_q    <= '0;
      cnt_q    <= '0;
      wu_q     <= 2'd0;
      pend_q   <= 1'b0;
      sample_q <= 16'h8000;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= bus.CMP_IN;
      sync2_q  <= sync1_q;
      d_q      <= sync2_q;
      // Feedback keeps running with the decimator disabled so the analog loop stays closed.
      fb_q     <= d_q ^ INV;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i2_dly_q <= i2_dly_d;
      c1_dly_q <= c1_dly_d;
      raw_q    <= raw_d;
      cnt_q    <= cnt_d;
      wu_q     <= wu_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.FB_OUT       = fb_q;
  assign bus.SAMPLE       = sample_q;
  assign bus.SAMPLE_VALID = valid_q;

endmodule
